alu_operand_loader: RTL and testbench



---
 rtl/alu_operand_loader.sv | 133 +++++++++++++
 tb/tb_alu_operand_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand loader for the mini-ALU: debounces the enter/back buttons and steps
// through capturing operand a, operand b and the function code from the switches.
module alu_operand_loader #(
  parameter int WIDTH     = 6,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_back,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       fxn,
  output logic             valid,
  output logic [1:0]       state,
  output logic             fxn_err
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_F = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t cur_state, nxt_state;

  // Index 0 is enter, index 1 is back; both buttons get identical treatment.
  logic [1:0]    raw, sync1, sync2, level, level_q, pulse;
  logic [CW-1:0] cnt [2];
  logic          enter_pulse, back_pulse;

  assign raw = {btn_back, btn_enter};

  // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pulse       = level & ~level_q;
  assign enter_pulse = pulse[0];
  assign back_pulse  = pulse[1];

  logic [WIDTH-1:0] nxt_a, nxt_b;
  logic [2:0]       nxt_fxn;
  logic             nxt_err, fxn_legal;

  // Codes 100 and 101 have no matching function in the mux stage.
  assign fxn_legal = !(sw[2] && !sw[1]);

  // Back takes priority over enter when both pulse together.
  always_comb begin
    nxt_state = cur_state;
    nxt_a     = a;
    nxt_b     = b;
    nxt_fxn   = fxn;
    nxt_err   = fxn_err;
    if (back_pulse) begin
      nxt_err = 1'b0;
      case (cur_state)
        LOAD_B:  nxt_state = LOAD_A;
        LOAD_F:  nxt_state = LOAD_B;
        RUN:     nxt_state = LOAD_F;
        default: nxt_state = cur_state;
      endcase
    end else if (enter_pulse) begin
      case (cur_state)
        LOAD_A: begin
          nxt_a     = sw;
          nxt_state = LOAD_B;
        end
        LOAD_B: begin
          nxt_b     = sw;
          nxt_state = LOAD_F;
        end
        LOAD_F: begin
          if (fxn_legal) begin
            nxt_fxn   = sw[2:0];
            nxt_err   = 1'b0;
            nxt_state = RUN;
          end else begin
            nxt_err = 1'b1;
          end
        end
        default: nxt_state = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= LOAD_A;
      a         <= '0;
      b         <= '0;
      fxn       <= 3'b000;
      fxn_err   <= 1'b0;
      valid     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      a         <= nxt_a;
      b         <= nxt_b;
      fxn       <= nxt_fxn;
      fxn_err   <= nxt_err;
      valid     <= (nxt_state == RUN);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: table of button presses with expected outputs,
// a scoreboard that pairs every output change with a queued expectation.
module tb_alu_operand_loader;

  localparam int WIDTH = 6;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic             btn_enter, btn_back;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       fxn;
  logic             valid, fxn_err;
  logic [1:0]       state;

  alu_operand_loader #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_back(btn_back),
    .a(a), .b(b), .fxn(fxn), .valid(valid), .state(state), .fxn_err(fxn_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] fxn;
    logic       valid;
    logic [1:0] state;
    logic       err;
  } obs_t;

  typedef struct {
    logic       enter;
    logic       back;
    logic [5:0] sw;
    obs_t       exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb_q[$];
  obs_t mon_prev;
  bit   mon_en = 0;
  obs_t model_exp;
  vec_t vecs[19];

  function automatic obs_t cur_obs();
    obs_t o;
    o.a = a; o.b = b; o.fxn = fxn; o.valid = valid; o.state = state; o.err = fxn_err;
    return o;
  endfunction

  function automatic string show(obs_t o);
    return $sformatf("a=%0d b=%0d fxn=%b valid=%b state=%0d err=%b",
                     o.a, o.b, o.fxn, o.valid, o.state, o.err);
  endfunction

  function automatic obs_t mk_obs(int ea, int eb, int ef, logic ev, int es, logic ee);
    obs_t o;
    o.a = 6'(ea); o.b = 6'(eb); o.fxn = 3'(ef); o.valid = ev; o.state = 2'(es); o.err = ee;
    return o;
  endfunction

  function automatic vec_t mk(logic e, logic bk, logic [5:0] s,
                              int ea, int eb, int ef, logic ev, int es, logic ee);
    vec_t v;
    v.enter = e; v.back = bk; v.sw = s;
    v.exp = mk_obs(ea, eb, ef, ev, es, ee);
    return v;
  endfunction

  // Scoreboard monitor: every change of the outputs must match the next queued expectation.
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_prev = cur_obs();
    end else if (cur_obs() !== mon_prev) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_change: got %s, required no change from %s",
                 show(cur_obs()), show(mon_prev));
      end else begin
        obs_t e;
        e = sb_q.pop_front();
        if (cur_obs() !== e) begin
          n_fail++;
          $display("[TB] FAIL scoreboard: got %s, required %s", show(cur_obs()), show(e));
        end
      end
      mon_prev = cur_obs();
    end
  end

  task automatic checkOutput(input string name, input obs_t exp);
    n_checks++;
    if (cur_obs() !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %s, required %s", name, show(cur_obs()), show(exp));
    end
  endtask

  // Hold the buttons long enough for one accepted press, then release and let it settle.
  task automatic applyStimulus(input string name, input vec_t v);
    int lat;
    bit change;
    @(negedge clk);
    sw        = v.sw;
    btn_enter = v.enter;
    btn_back  = v.back;
    change    = (v.exp !== model_exp);
    if (change) sb_q.push_back(v.exp);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && cur_obs() !== model_exp) lat = i;
    end
    if (change) begin
      n_checks++;
      if (lat != DB + 2) begin
        n_fail++;
        $display("[TB] FAIL %s_latency: got %0d edges, required %0d", name, lat, DB + 2);
      end
    end
    @(negedge clk);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput(name, v.exp);
    model_exp = v.exp;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = mk(1, 0, 6'd13,       13, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 6'd7,        13, 7, 0, 0, 2, 0);
    vecs[2]  = mk(1, 0, 6'b000110,   13, 7, 6, 1, 3, 0);
    vecs[3]  = mk(1, 0, 6'd40,       13, 7, 6, 0, 0, 0);
    vecs[4]  = mk(0, 1, 6'd33,       13, 7, 6, 0, 0, 0);
    vecs[5]  = mk(1, 0, 6'd5,         5, 7, 6, 0, 1, 0);
    vecs[6]  = mk(1, 0, 6'd9,         5, 9, 6, 0, 2, 0);
    vecs[7]  = mk(1, 0, 6'b111101,    5, 9, 6, 0, 2, 1);
    vecs[8]  = mk(1, 0, 6'b000100,    5, 9, 6, 0, 2, 1);
    vecs[9]  = mk(1, 0, 6'b111011,    5, 9, 3, 1, 3, 0);
    vecs[10] = mk(0, 1, 6'd0,         5, 9, 3, 0, 2, 0);
    vecs[11] = mk(0, 1, 6'd0,         5, 9, 3, 0, 1, 0);
    vecs[12] = mk(1, 1, 6'd50,        5, 9, 3, 0, 0, 0);
    vecs[13] = mk(1, 0, 6'd63,       63, 9, 3, 0, 1, 0);
    vecs[14] = mk(1, 0, 6'd1,        63, 1, 3, 0, 2, 0);
    vecs[15] = mk(1, 0, 6'b000101,   63, 1, 3, 0, 2, 1);
    vecs[16] = mk(0, 1, 6'd0,        63, 1, 3, 0, 1, 0);
    vecs[17] = mk(1, 0, 6'd2,        63, 2, 3, 0, 2, 0);
    vecs[18] = mk(1, 0, 6'd0,        63, 2, 0, 1, 3, 0);

    rst = 1'b1; sw = '0; btn_enter = 1'b0; btn_back = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_exp = mk_obs(0, 0, 0, 0, 0, 0);
    checkOutput("reset_state", model_exp);
    mon_en = 1;

    for (int i = 0; i < 19; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Reset while an enter press is half-way through debounce.
    @(negedge clk);
    btn_enter = 1'b1;
    sw = 6'd44;
    repeat (3) @(negedge clk);
    model_exp = mk_obs(0, 0, 0, 0, 0, 0);
    sb_q.push_back(model_exp);
    rst = 1'b1;
    btn_enter = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("reset_mid_press", model_exp);

    // Bouncing enter: only the final long hold may capture.
    sw = 6'd21;
    model_exp = mk_obs(21, 0, 0, 0, 1, 0);
    sb_q.push_back(model_exp);
    for (int k = 0; k < 5; k++) begin
      btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      btn_enter = 1'b0;
      @(negedge clk);
    end
    btn_enter = 1'b1;
    repeat (10) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("bounce_single_capture", model_exp);

    repeat (4) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
